// File: rtl/eth_tx_arbiter.sv
// Two-source arbiter for the RMII transmit port: round-robin grant, one frame per grant,
// inter-frame gap enforcement and a watchdog on grants that never start a frame.
module eth_tx_arbiter #(
  parameter int N             = 2,
  parameter int IFG_CYCLES    = 48,
  parameter int GRANT_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  output logic [1:0]   gnt,
  input  logic         s0_axiiv,
  input  logic [N-1:0] s0_axiid,
  input  logic         s1_axiiv,
  input  logic [N-1:0] s1_axiid,
  output logic         axiov,
  output logic [N-1:0] axiod,
  output logic         busy,
  output logic         timeout
);

  localparam int WW = (GRANT_TIMEOUT > 1) ? $clog2(GRANT_TIMEOUT) : 1;
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [WW-1:0] WD_TERM  = WW'(GRANT_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_TERM = GW'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GRANT, SEND, GAP} state_t;

  state_t        state;
  logic          last;
  logic [WW-1:0] wdog;
  logic [WW-1:0] wdog_next;
  logic [GW-1:0] gap_cnt;
  logic          sel_valid;
  logic [N-1:0]  sel_data;
  logic          sel_req;
  logic          fwd;
  logic          winner;

  // `last` doubles as the selected source while a grant is outstanding.
  always_comb begin
    sel_valid = last ? s1_axiiv : s0_axiiv;
    sel_data  = last ? s1_axiid : s0_axiid;
    sel_req   = last ? req[1] : req[0];
    fwd       = ((state == GRANT) || (state == SEND)) && sel_valid;
    wdog_next = wdog + 1'b1;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      default: winner = ~last;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= 2'b00;
      last    <= 1'b1;
      wdog    <= '0;
      gap_cnt <= '0;
      axiov   <= 1'b0;
      axiod   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      axiov   <= fwd;
      axiod   <= fwd ? sel_data : '0;
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req) begin
            gnt   <= winner ? 2'b10 : 2'b01;
            last  <= winner;
            wdog  <= '0;
            state <= GRANT;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (sel_valid) begin
            state <= SEND;
          end else if (!sel_req) begin
            gnt   <= 2'b00;
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wdog_next == WD_TERM) begin
            // Revoke on the edge where the count reaches its terminal value.
            gnt     <= 2'b00;
            timeout <= 1'b1;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            wdog <= wdog_next;
          end
        end
        SEND: begin
          if (!sel_valid) begin
            gnt     <= 2'b00;
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_TERM) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: a scoreboard queue of expected beats is filled by
// the source drivers and drained by a monitor; each scenario task checks control timing inline.
module tb_eth_tx_arbiter;

  localparam int N   = 2;
  localparam int IFG = 48;
  localparam int GTO = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req = 2'b00;
  logic         s0_axiiv = 1'b0;
  logic [N-1:0] s0_axiid = '0;
  logic         s1_axiiv = 1'b0;
  logic [N-1:0] s1_axiid = '0;
  logic [1:0]   gnt;
  logic         axiov;
  logic [N-1:0] axiod;
  logic         busy;
  logic         timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int beat_cnt = 0;
  int low_run = 0;
  int last_gap = 0;
  logic [N-1:0] exp_q[$];

  eth_tx_arbiter #(.N(N), .IFG_CYCLES(IFG), .GRANT_TIMEOUT(GTO)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .s0_axiiv(s0_axiiv), .s0_axiid(s0_axiid),
    .s1_axiiv(s1_axiiv), .s1_axiid(s1_axiid),
    .axiov(axiov), .axiod(axiod), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every forwarded beat must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [N-1:0] e;
    n_cmp++;
    if (axiov === 1'b1) begin
      beat_cnt++;
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("[TB] FAIL sb_unexpected: axiod=%0d with no beat expected", axiod);
      end else begin
        e = exp_q.pop_front();
        if (axiod !== e) begin
          n_bad++;
          $display("[TB] FAIL sb_data: axiod=%0d expected %0d", axiod, e);
        end
      end
    end else begin
      low_run++;
      if (axiod !== '0) begin
        n_bad++;
        $display("[TB] FAIL idle_data: axiod=%0d expected 0 while axiov=%b", axiod, axiov);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt_any(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (gnt !== 2'b00) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      if (busy === 1'b0) ok = 1'b1;
      else tick();
    end
  endtask

  // Drive n beats from one source, data = (i % modv) + base, queuing each as expected output.
  task automatic send_beats(input int src, input int n, input int modv, input int base);
    logic [N-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = N'((i % modv) + base);
      if (src == 0) begin
        s0_axiiv = 1'b1;
        s0_axiid = d;
      end else begin
        s1_axiiv = 1'b1;
        s1_axiid = d;
      end
      exp_q.push_back(d);
      tick();
    end
    if (src == 0) begin
      s0_axiiv = 1'b0;
      s0_axiid = '0;
    end else begin
      s1_axiiv = 1'b0;
      s1_axiid = '0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'b00;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({gnt, axiov, axiod, busy, timeout} !== '0) begin
        n_bad++;
        $display("[TB] FAIL reset_outputs: gnt=%b axiov=%b axiod=%0d busy=%b timeout=%b expected all 0",
                 gnt, axiov, axiod, busy, timeout);
      end
    end
  endtask

  task automatic test_single_frame();
    bit ok;
    int b0, t_fall;
    req = 2'b01;
    wait_gnt_any(10, ok);
    n_cmp++;
    if (!ok || gnt !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL single_grant: gnt=%b expected 01", gnt);
    end
    b0 = beat_cnt;
    send_beats(0, 20, 4, 0);
    n_cmp++;
    if (gnt !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL single_gnt_hold: gnt=%b expected 01 at last beat edge", gnt);
    end
    tick();
    t_fall = cyc;
    req = 2'b00;
    n_cmp++;
    if (gnt !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL single_gnt_fall: gnt=%b expected 00 one edge after last beat", gnt);
    end
    n_cmp++;
    if (beat_cnt - b0 !== 20) begin
      n_bad++;
      $display("[TB] FAIL single_beat_count: beats=%0d expected 20", beat_cnt - b0);
    end
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || (cyc - t_fall) != IFG) begin
      n_bad++;
      $display("[TB] FAIL single_busy_fall: busy fell %0d cycles after gnt fall (ok=%0d) expected %0d",
               cyc - t_fall, ok, IFG);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_src;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_src = k % 2;
      wait_gnt_any(200, ok);
      n_cmp++;
      if (!ok || gnt !== (exp_src == 1 ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("[TB] FAIL rr_grant_%0d: gnt=%b expected source %0d", k, gnt, exp_src);
      end
      send_beats(exp_src, 10, 4, k);
      tick();
      n_cmp++;
      if (gnt !== 2'b00) begin
        n_bad++;
        $display("[TB] FAIL rr_release_%0d: gnt=%b expected 00", k, gnt);
      end
      if (k > 0) begin
        n_cmp++;
        if (last_gap < IFG + 2) begin
          n_bad++;
          $display("[TB] FAIL rr_gap_%0d: idle gap=%0d expected >= %0d", k, last_gap, IFG + 2);
        end
      end
    end
    req = 2'b00;
  endtask

  task automatic test_isolation();
    bit ok;
    wait_idle(200, ok);
    req = 2'b01;
    s1_axiiv = 1'b1;
    s1_axiid = 2'b11;
    wait_gnt_any(10, ok);
    n_cmp++;
    if (!ok || gnt !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL iso_grant: gnt=%b expected 01", gnt);
    end
    send_beats(0, 8, 2, 1);
    tick();
    req = 2'b00;
    n_cmp++;
    if (gnt !== 2'b00) begin
      n_bad++;
      $display("[TB] FAIL iso_release: gnt=%b expected 00", gnt);
    end
    repeat (3) tick();
    s1_axiiv = 1'b0;
    s1_axiid = '0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL iso_drain: %0d beats outstanding expected 0", exp_q.size());
    end
  endtask

  task automatic test_watchdog();
    bit ok;
    bit hit;
    int g, t;
    wait_idle(200, ok);
    req = 2'b10;
    wait_gnt_any(10, ok);
    g = cyc;
    n_cmp++;
    if (!ok || gnt !== 2'b10) begin
      n_bad++;
      $display("[TB] FAIL wd_grant: gnt=%b expected 10", gnt);
    end
    hit = 1'b0;
    t = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (timeout === 1'b1) begin
        hit = 1'b1;
        t = cyc;
      end
    end
    req = 2'b00;
    n_cmp++;
    if (!hit || (t - g) != GTO - 1) begin
      n_bad++;
      $display("[TB] FAIL wd_latency: timeout after %0d cycles (seen=%0d) expected %0d", t - g, hit, GTO - 1);
    end
    n_cmp++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL wd_revoke: gnt=%b busy=%b expected 00/0", gnt, busy);
    end
    tick();
    n_cmp++;
    if (timeout !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL wd_single_pulse: timeout=%b gnt=%b busy=%b expected 0/00/0", timeout, gnt, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    wait_idle(200, ok);
    req = 2'b01;
    wait_gnt_any(10, ok);
    n_cmp++;
    if (!ok || gnt !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL rmf_grant: gnt=%b expected 01", gnt);
    end
    for (int i = 0; i < 5; i++) begin
      s0_axiiv = 1'b1;
      s0_axiid = N'(i + 1);
      exp_q.push_back(N'(i + 1));
      tick();
    end
    s0_axiid = 2'b10;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({gnt, axiov, axiod, busy, timeout} !== '0) begin
      n_bad++;
      $display("[TB] FAIL rmf_outputs: gnt=%b axiov=%b axiod=%0d busy=%b timeout=%b expected all 0",
               gnt, axiov, axiod, busy, timeout);
    end
    s0_axiiv = 1'b0;
    s0_axiid = '0;
    req = 2'b11;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 2'b01) begin
      n_bad++;
      $display("[TB] FAIL rmf_first_tie: gnt=%b expected 01", gnt);
    end
    req = 2'b00;
    tick();
    n_cmp++;
    if (gnt !== 2'b00 || busy !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL rmf_req_drop: gnt=%b busy=%b expected 00/0", gnt, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("[TB] FAIL rmf_drain: %0d beats outstanding expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_isolation();
    test_watchdog();
    test_reset_mid_frame();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] time limit");
  end

endmodule
